cic_interpolator: RTL and testbench
===================================

CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 The block SHALL have parameter G_I_W, default 6, meaning input sample width (signed two's complement).
REQ-002 The block SHALL have parameter G_R_W, default 2, meaning log2 of the interpolation ratio R = 2**G_R_W.
REQ-003 The block SHALL have parameter G_N, default 2, meaning number of comb and integrator stages (differential delay 1).
REQ-004 The block SHALL derive G_O_W = G_I_W + (G_N-1)*G_R_W as a localparam, not overridable.
REQ-005 The block SHALL have port i_clk, input, 1, clock; all logic on the rising edge.
REQ-006 The block SHALL have port i_rst, input, 1, reset, synchronous, active-high.
REQ-007 The block SHALL have port i_valid, input, 1, meaning an input sample is offered.
REQ-008 The block SHALL have port o_ready, output, 1, meaning the block accepts i_sample this cycle.
REQ-009 The block SHALL have port i_sample, input, G_I_W, meaning a signed input sample.
REQ-010 The block SHALL have port o_valid, output, 1, meaning o_result holds an output sample.
REQ-011 The block SHALL have port i_ready, input, 1, meaning downstream takes o_result this cycle.
REQ-012 The block SHALL have port o_result, output, G_O_W, meaning a signed interpolated sample.

Function
REQ-013 Input accept SHALL be i_valid && o_ready; output handshake SHALL be o_valid && i_ready.
REQ-014 FSM states SHALL be S_IDLE (o_valid=0) and S_OUT (o_valid=1), with a phase counter 0..R-1.
REQ-015 o_ready SHALL be 1 in S_IDLE, and 1 in S_OUT only when phase==R-1 && i_ready; otherwise 0.
REQ-016 On accept, the comb cascade SHALL compute c0=i_sample and ck=c(k-1)-dk for k=1..G_N, then update dk<=c(k-1).
REQ-017 On accept, the integrator cascade SHALL update with input cN: I1'=I1+cN, Ik'=Ik+I(k-1)' (combinational chain, one edge), with phase<=0 and state<=S_OUT.
REQ-018 On an output handshake with phase<R-1, the integrators SHALL update per REQ-017 with input 0, and phase SHALL increment.
REQ-019 On an output handshake with phase==R-1 and no simultaneous accept, the state SHALL go to S_IDLE and integrators SHALL hold.
REQ-020 A handshake at phase==R-1 with a simultaneous accept SHALL apply REQ-017 only, with no idle bubble, giving one output per cycle under continuous traffic.
REQ-021 o_result SHALL be a register loaded with IN' on every integrator update: latency 1 cycle from accept to o_valid.
REQ-022 With o_valid=1 and i_ready=0, o_result, phase and all state SHALL hold.
REQ-023 Comb and integrator registers SHALL be G_O_W bits wide with modulo-2**G_O_W wrap, no saturation; i_sample SHALL be sign-extended.
REQ-024 In S_IDLE the comb delays and integrators SHALL hold their values.

Reset
REQ-025 Reset SHALL clear all comb delays, integrators, phase and o_result to 0, set state to S_IDLE, o_valid=0 and o_ready=1 (first cycle after reset).
REQ-026 Reset mid-burst SHALL abandon the burst; the remaining phases SHALL NOT be output.

Configuration
REQ-027 With macro CIC_GAIN_COMP_EN defined, o_result SHALL be IN' arithmetically shifted right by (G_N-1)*G_R_W and sign-extended to G_O_W (unity DC gain).
REQ-028 Without CIC_GAIN_COMP_EN, o_result SHALL be raw IN' (DC gain R**(G_N-1)).

Structure
REQ-029 Package cic_pkg SHALL hold the state enum type and a function computing G_O_W from (G_I_W, G_R_W, G_N).
REQ-030 One sub-module, cic_comb_stage (one delay register plus subtractor, enable input), SHALL be instantiated G_N times via generate.

Verification (defaults, no macro unless stated; i_ready=1 unless stated)
REQ-031 Impulse: input 1 then three 0 samples -> o_result sequence 1,2,3,4,3,2,1,0,0,... (12 samples).
REQ-032 Step of 5 held -> output settles to 20; with CIC_GAIN_COMP_EN it settles to 5.
REQ-033 Back-to-back i_valid=1 -> o_valid continuous, o_ready pulses once per 4 cycles, no bubbles.
REQ-034 i_ready=0 for 3 cycles at phase 1 -> o_result and phase frozen; the sequence resumes unchanged.
REQ-035 Full-scale input -32 held -> output settles to -128 with no wrap error; input 31 held -> 124.
REQ-036 i_rst asserted at phase 2 -> next cycle o_valid=0, o_ready=1, o_result=0; a fresh impulse reproduces REQ-031.

Source files
------------

// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared state type and width helper for the CIC interpolator.
package cic_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OUT  = 1'b1
    } cic_state_t;

    // Register growth of an interpolating CIC with differential delay 1.
    function automatic int cic_out_width(input int i_w, input int r_w, input int n);
        return i_w + (n - 1) * r_w;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one comb section: delay register plus subtractor.
module cic_comb_stage #(
    parameter int G_W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    input  logic [G_W-1:0] i_data,
    output logic [G_W-1:0] o_data
);

    logic [G_W-1:0] r_dly;

    assign o_data = i_data - r_dly;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dly <= '0;
        end else if (i_en) begin
            r_dly <= i_data;
        end
    end

endmodule

// File: rtl/cic_interpolator.sv
// rtl/cic_interpolator.sv - CIC interpolator, ratio 2**G_R_W, G_N stages, valid/ready on both sides.
// Optional CIC_GAIN_COMP_EN: output shifted down to unity DC gain.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter  int G_I_W = 6,
    parameter  int G_R_W = 2,
    parameter  int G_N   = 2,
    localparam int G_O_W = cic_out_width(G_I_W, G_R_W, G_N)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [G_I_W-1:0] i_sample,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [G_O_W-1:0] o_result
);

    localparam int R  = 2 ** G_R_W;
    localparam int SH = (G_N - 1) * G_R_W;

    cic_state_t       r_state;
    cic_state_t       w_state_nxt;
    logic [G_R_W-1:0] r_phase;
    logic             w_last;
    logic             w_accept;
    logic             w_hs;
    logic             w_integ_en;
    logic [G_O_W-1:0] w_comb      [G_N+1];
    logic [G_O_W-1:0] r_integ     [G_N];
    logic [G_O_W-1:0] w_integ_nxt [G_N];
    logic [G_O_W-1:0] w_res;

    assign w_last = (r_phase == G_R_W'(R - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                o_valid = 1'b1;
                o_ready = w_last && i_ready;
                // Last phase taken with no new sample waiting: drop back to idle.
                if (w_last && i_ready && !i_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept   = i_valid && o_ready;
    assign w_hs       = o_valid && i_ready;
    assign w_integ_en = w_accept || (w_hs && !w_last);

    assign w_comb[0] = G_O_W'($signed(i_sample));

    for (genvar k = 0; k < G_N; k++) begin : g_comb
        cic_comb_stage #(
            .G_W(G_O_W)
        ) u_comb (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_en   (w_accept),
            .i_data (w_comb[k]),
            .o_data (w_comb[k+1])
        );
    end

    // Zero-stuffing: integrators see the comb output on accept, zero otherwise.
    always_comb begin
        w_integ_nxt[0] = r_integ[0] + (w_accept ? w_comb[G_N] : '0);
        for (int k = 1; k < G_N; k++) begin
            w_integ_nxt[k] = r_integ[k] + w_integ_nxt[k-1];
        end
    end

`ifdef CIC_GAIN_COMP_EN
    assign w_res = G_O_W'($signed(w_integ_nxt[G_N-1]) >>> SH);
`else
    assign w_res = w_integ_nxt[G_N-1];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < G_N; k++) begin
                r_integ[k] <= '0;
            end
            r_phase  <= '0;
            o_result <= '0;
        end else if (w_integ_en) begin
            for (int k = 0; k < G_N; k++) begin
                r_integ[k] <= w_integ_nxt[k];
            end
            o_result <= w_res;
            r_phase  <= w_accept ? '0 : r_phase + 1'b1;
        end
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// tb/tb_cic_interpolator.sv - randomized and directed checks of cic_interpolator against a convolution model.
module tb_cic_interpolator;

    localparam int IW = 6;
    localparam int N  = 2;
    localparam int R  = 4;
    localparam int OW = 8;
`ifdef CIC_GAIN_COMP_EN
    localparam int SH = 2;
`else
    localparam int SH = 0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [IW-1:0] i_sample = '0;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic [OW-1:0] o_result;

    always #5 i_clk = ~i_clk;

    cic_interpolator dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sample (i_sample),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   h[$];
    int   xs[$];
    int   got[$];
    int   stim[$];
    int   out_idx = 0;
    logic last_vld;
    logic last_rdy;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Impulse response of (1 + z^-1 + ... + z^-(R-1))^N at the output rate.
    task automatic build_h();
        int t[$];
        h = {1};
        repeat (N) begin
            t = {};
            for (int i = 0; i < h.size() + R - 1; i++) begin
                int s = 0;
                for (int j = 0; j < R; j++) begin
                    if (i - j >= 0 && i - j < h.size()) s += h[i-j];
                end
                t.push_back(s);
            end
            h = t;
        end
    endtask

    function automatic int model_y(input int n);
        int acc = 0;
        logic signed [OW-1:0] w;
        for (int j = 0; j < h.size(); j++) begin
            int k = n - j;
            if (k >= 0 && (k % R) == 0 && (k / R) < xs.size()) acc += h[j] * xs[k/R];
        end
        w = acc[OW-1:0];
        return int'(w >>> SH);
    endfunction

    task automatic step(input logic v, input int s, input logic rdy, output logic acc);
        int obs;
        @(negedge i_clk);
        i_valid  = v;
        i_sample = s[IW-1:0];
        i_ready  = rdy;
        #1;
        last_vld = o_valid;
        last_rdy = o_ready;
        acc = v && o_ready;
        if (o_valid && rdy) begin
            obs = int'($signed(o_result));
            check_val($sformatf("out%0d", out_idx), obs, model_y(out_idx));
            got.push_back(obs);
            out_idx++;
        end
        if (acc) xs.push_back(s);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check_val({tag, "_valid"}, int'(o_valid), 0);
        check_val({tag, "_ready"}, int'(o_ready), 1);
        check_val({tag, "_result"}, int'($signed(o_result)), 0);
        i_rst = 1'b0;
        xs = {};
        got = {};
        stim = {};
        out_idx = 0;
    endtask

    task automatic feed(input int max_cyc, input int vpct, input int rpct);
        int   c = 0;
        logic v, rdy, acc;
        while ((stim.size() > 0 || o_valid) && c < max_cyc) begin
            v   = (stim.size() > 0) && ($urandom_range(99) < vpct);
            rdy = ($urandom_range(99) < rpct);
            step(v, v ? stim[0] : 0, rdy, acc);
            if (acc) void'(stim.pop_front());
            c++;
        end
        check_val("drain_done", int'(stim.size() == 0 && !o_valid), 1);
    endtask

    task automatic check_imp(input string tag);
        int imp[12] = '{1, 2, 3, 4, 3, 2, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            check_val($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : -999, imp[i] >>> SH);
        end
    endtask

    task automatic check_settle(input string tag, input int exp);
        check_val(tag, (got.size() > 0) ? got[got.size()-1] : -999, exp >>> SH);
    endtask

    initial begin
        logic acc;
        int   nv, nr;
        build_h();
        do_reset("rst0");

        stim = {1, 0, 0, 0};
        feed(200, 100, 100);
        check_imp("imp");

        do_reset("rst1");
        repeat (6) stim.push_back(5);
        feed(200, 100, 100);
        check_settle("step5", 20);

        do_reset("rst2");
        repeat (6) stim.push_back(-32);
        feed(200, 100, 100);
        check_settle("stepm32", -128);

        do_reset("rst3");
        repeat (6) stim.push_back(31);
        feed(200, 100, 100);
        check_settle("step31", 124);

        do_reset("rst4");
        repeat (8) stim.push_back($urandom_range(0, 63) - 32);
        step(1'b1, stim[0], 1'b1, acc);
        if (acc) void'(stim.pop_front());
        nv = 0;
        nr = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, stim[0], 1'b1, acc);
            if (acc) void'(stim.pop_front());
            nv += int'(last_vld);
            nr += int'(last_rdy);
        end
        check_val("b2b_valid", nv, 16);
        check_val("b2b_ready", nr, 4);
        feed(200, 100, 100);

        do_reset("rst5");
        step(1'b1, 1, 1'b1, acc);
        step(1'b0, 0, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 1'b0, acc);
            check_val($sformatf("stall_valid%0d", i), int'(last_vld), 1);
            check_val($sformatf("stall_res%0d", i), int'($signed(o_result)), 2 >>> SH);
        end
        stim = {0, 0, 0};
        feed(200, 100, 100);
        check_imp("stall");

        do_reset("rst6");
        step(1'b1, 1, 1'b1, acc);
        step(1'b0, 0, 1'b1, acc);
        step(1'b0, 0, 1'b1, acc);
        do_reset("midrst");
        stim = {1, 0, 0, 0};
        feed(200, 100, 100);
        check_imp("imp2");

        for (int r = 0; r < 3; r++) begin
            do_reset($sformatf("rrst%0d", r));
            repeat (30) stim.push_back($urandom_range(0, 63) - 32);
            feed(2000, 60, 70);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
